// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the sequential ALU
package alu_pkg;

    typedef enum logic [2:0] {
        MODO_ADD = 3'b000,
        MODO_SUB = 3'b001,
        MODO_MUL = 3'b010,
        MODO_SHL = 3'b011,
        MODO_SHR = 3'b100,
        MODO_AND = 3'b101,
        MODO_OR  = 3'b110,
        MODO_XOR = 3'b111
    } modo_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per enabled clock
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc_next;

    // done flags the iteration that completes at the coming enabled edge;
    // product already includes that final partial product.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (cnt == CW'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (en) begin
            if (start && !busy) begin
                busy   <= 1'b1;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
            end else if (busy) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (done) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - parametrised sequential ALU, eight modes, start/busy/done handshake
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       modo,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    state_e             state, next_state;
    modo_e              op;
    logic               op_fire;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_c;
    logic               alu_carry;
    logic               alu_ovf;

    assign op = modo_e'(modo);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= next_state;
        end
    end

    // Start is honoured only in IDLE, so a strobe during MUL is dropped.
    always_comb begin
        next_state = state;
        op_fire    = 1'b0;
        mul_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == MODO_MUL) begin
                        mul_start  = 1'b1;
                        next_state = ST_MUL;
                    end else begin
                        op_fire = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_c     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            MODO_ADD: begin
                alu_c     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            MODO_SUB: begin
                alu_c     = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            MODO_SHL: alu_c = (b >= SHIFT_LIM) ? '0 : (a << b);
            MODO_SHR: alu_c = (b >= SHIFT_LIM) ? '0 : (a >> b);
            MODO_AND: alu_c = a & b;
            MODO_OR:  alu_c = a | b;
            MODO_XOR: alu_c = a ^ b;
            default:  alu_c = '0;
        endcase
    end

    // Result registers only move on a completed command; done is cleared
    // by any other enabled edge, so it stretches while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c     <= '0;
            c_hi  <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            done  <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            if (op_fire) begin
                c     <= alu_c;
                c_hi  <= '0;
                carry <= alu_carry;
                ovf   <= alu_ovf;
                zero  <= (alu_c == '0);
                done  <= 1'b1;
            end else if (state == ST_MUL && mul_done) begin
                c     <= mul_product[WIDTH-1:0];
                c_hi  <= mul_product[2*WIDTH-1:WIDTH];
                carry <= 1'b0;
                ovf   <= 1'b0;
                zero  <= (mul_product == '0);
                done  <= 1'b1;
            end
        end
    end

    assign busy = mul_busy;

endmodule
